frame_painter: RTL and testbench

- Downstream of the snake-grid frame tracker. It drives the tracker's scan enable and consumes its per-cell change report (obj_code, x, y, diff).
- For every changed cell, it emits an ILI9341-style command/data word stream that repaints one CELL_W x CELL_H pixel tile in the colour of the new object.
- It stalls the tracker scan while a tile is being sent, so no change report is lost.

---
 rtl/frame_painter.sv | 182 ++++++++++++++++++
 tb/tb_frame_painter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_painter.sv
// Repaints one grid tile on an ILI9341-style display for every cell change the
// snake-grid frame tracker reports, stalling the tracker scan while a tile streams out.
module frame_painter #(
  parameter int CELL_W = 20,
  parameter int CELL_H = 20,
  parameter int GRID_W = 16,
  parameter int GRID_H = 12
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        run,
  input  logic [2:0]  obj_code,
  input  logic [3:0]  x,
  input  logic [3:0]  y,
  input  logic        diff,
  output logic        scan_en,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_data,
  output logic        pix_dc,
  output logic        busy,
  output logic        sweep_done
);

  localparam int NPIX  = CELL_W * CELL_H;
  localparam int PIX_W = $clog2(NPIX);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);

  typedef enum logic [2:0] {
    IDLE,
    CASET_CMD,
    CASET_D,
    RASET_CMD,
    RASET_D,
    RAMWR_CMD,
    PIXELS
  } state_t;

  state_t           state;
  logic [3:0]       cell_x;
  logic [3:0]       cell_y;
  logic [2:0]       cell_code;
  logic [1:0]       byte_cnt;
  logic [PIX_W-1:0] pix_cnt;
  logic [15:0]      x0, x1, y0, y1;
  logic [15:0]      colour;
  logic             capture;
  logic             accept;

  assign scan_en = run && (state == IDLE);
  assign busy    = (state != IDLE);
  assign capture = scan_en && diff;
  assign accept  = pix_valid && pix_ready;

  assign x0 = 16'(cell_x) * 16'(CELL_W);
  assign x1 = x0 + 16'(CELL_W - 1);
  assign y0 = 16'(cell_y) * 16'(CELL_H);
  assign y1 = y0 + 16'(CELL_H - 1);

  // Codes outside the known object set show up as magenta so they stand out on screen.
  always_comb begin
    colour = 16'hF81F;
    case (cell_code)
      3'd0:    colour = 16'h0000;
      3'd1:    colour = 16'hFFE0;
      3'd2:    colour = 16'h07E0;
      3'd3:    colour = 16'hF800;
      3'd4:    colour = 16'h001F;
      default: colour = 16'hF81F;
    endcase
  end

  function automatic logic [15:0] coord_byte(input logic [15:0] c_lo, input logic [15:0] c_hi,
                                             input logic [1:0] idx);
    case (idx)
      2'd0:    coord_byte = {8'h00, c_lo[15:8]};
      2'd1:    coord_byte = {8'h00, c_lo[7:0]};
      2'd2:    coord_byte = {8'h00, c_hi[15:8]};
      default: coord_byte = {8'h00, c_hi[7:0]};
    endcase
  endfunction

  // Each handshake loads the following word, so the output register always holds the
  // word for the current state/counter and stays frozen while the sink stalls.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cell_x    <= '0;
      cell_y    <= '0;
      cell_code <= '0;
      byte_cnt  <= '0;
      pix_cnt   <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_dc    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            cell_x    <= x;
            cell_y    <= y;
            cell_code <= obj_code;
            state     <= CASET_CMD;
            pix_valid <= 1'b1;
            pix_data  <= 16'h002A;
            pix_dc    <= 1'b0;
          end
        end
        CASET_CMD: begin
          if (accept) begin
            state    <= CASET_D;
            byte_cnt <= 2'd0;
            pix_data <= coord_byte(x0, x1, 2'd0);
            pix_dc   <= 1'b1;
          end
        end
        CASET_D: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state    <= RASET_CMD;
              pix_data <= 16'h002B;
              pix_dc   <= 1'b0;
            end else begin
              pix_data <= coord_byte(x0, x1, byte_cnt + 2'd1);
            end
          end
        end
        RASET_CMD: begin
          if (accept) begin
            state    <= RASET_D;
            byte_cnt <= 2'd0;
            pix_data <= coord_byte(y0, y1, 2'd0);
            pix_dc   <= 1'b1;
          end
        end
        RASET_D: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state    <= RAMWR_CMD;
              pix_data <= 16'h002C;
              pix_dc   <= 1'b0;
            end else begin
              pix_data <= coord_byte(y0, y1, byte_cnt + 2'd1);
            end
          end
        end
        RAMWR_CMD: begin
          if (accept) begin
            state    <= PIXELS;
            pix_cnt  <= '0;
            pix_data <= colour;
            pix_dc   <= 1'b1;
          end
        end
        PIXELS: begin
          if (accept) begin
            if (pix_cnt == PIX_LAST) begin
              state     <= IDLE;
              pix_valid <= 1'b0;
              pix_data  <= '0;
              pix_dc    <= 1'b0;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= scan_en && (x == 4'(GRID_W - 1)) && (y == 4'(GRID_H - 1));
    end
  end

endmodule

// File: tb/tb_frame_painter.sv
// Directed bench for frame_painter: tile word streams, backpressure, corner tiles,
// sweep pulses, run pause and mid-tile reset.
module tb_frame_painter;

  logic        clk;
  logic        nrst;
  logic        run;
  logic [2:0]  obj_code;
  logic [3:0]  x;
  logic [3:0]  y;
  logic        diff;
  logic        scan_en;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic        pix_dc;
  logic        busy;
  logic        sweep_done;

  int n_checks = 0;
  int n_fail   = 0;

  frame_painter dut (
    .clk(clk), .nrst(nrst), .run(run), .obj_code(obj_code), .x(x), .y(y), .diff(diff),
    .scan_en(scan_en), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_dc(pix_dc), .busy(busy), .sweep_done(sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference word for position idx of a tile: {dc, data}.
  function automatic logic [16:0] exp_word(input int idx, input logic [3:0] cx,
                                           input logic [3:0] cy, input logic [2:0] code);
    int xa, xb, ya, yb;
    logic [15:0] col;
    xa = cx * 20; xb = xa + 19; ya = cy * 20; yb = ya + 19;
    case (code)
      3'd0: col = 16'h0000;
      3'd1: col = 16'hFFE0;
      3'd2: col = 16'h07E0;
      3'd3: col = 16'hF800;
      3'd4: col = 16'h001F;
      default: col = 16'hF81F;
    endcase
    case (idx)
      0:  exp_word = {1'b0, 16'h002A};
      1:  exp_word = {1'b1, 8'h00, 8'((xa >> 8) & 255)};
      2:  exp_word = {1'b1, 8'h00, 8'(xa & 255)};
      3:  exp_word = {1'b1, 8'h00, 8'((xb >> 8) & 255)};
      4:  exp_word = {1'b1, 8'h00, 8'(xb & 255)};
      5:  exp_word = {1'b0, 16'h002B};
      6:  exp_word = {1'b1, 8'h00, 8'((ya >> 8) & 255)};
      7:  exp_word = {1'b1, 8'h00, 8'(ya & 255)};
      8:  exp_word = {1'b1, 8'h00, 8'((yb >> 8) & 255)};
      9:  exp_word = {1'b1, 8'h00, 8'(yb & 255)};
      10: exp_word = {1'b0, 16'h002C};
      default: exp_word = {1'b1, col};
    endcase
  endfunction

  // Captures one cell change and streams the resulting tile, checking every word.
  task automatic run_tile(input logic [3:0] cx, input logic [3:0] cy, input logic [2:0] code,
                          input bit rnd, input bit hold_diff, input bit drop_run,
                          output int hs, output int low_cyc, output int sweeps);
    logic [16:0] expw;
    logic [15:0] prev_data;
    logic        prev_dc;
    bit          prev_stall;
    bit          done;
    hs = 0; low_cyc = 0; sweeps = 0; prev_stall = 0; done = 0;
    prev_data = '0; prev_dc = 1'b0;
    @(negedge clk);
    run = 1'b1; x = cx; y = cy; obj_code = code; diff = 1'b1; pix_ready = 1'b1;
    @(posedge clk);
    #1;
    if (hold_diff) begin x = 4'd5; y = 4'd5; end
    else begin diff = 1'b0; x = 4'd0; y = 4'd0; end
    if (drop_run) run = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sweep_done) sweeps++;
      if (!busy) begin done = 1; break; end
      if (!scan_en) low_cyc++;
      n_checks++;
      if (pix_valid !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL valid_gap: pix_valid=%b required 1 at word %0d", pix_valid, hs);
      end
      if (prev_stall) begin
        n_checks++;
        if ({pix_dc, pix_data} !== {prev_dc, prev_data}) begin
          n_fail++;
          $display("[TB] FAIL stall_hold: got dc=%b data=%h required dc=%b data=%h",
                   pix_dc, pix_data, prev_dc, prev_data);
        end
      end
      if (pix_valid && pix_ready) begin
        expw = exp_word(hs, cx, cy, code);
        n_checks++;
        if ({pix_dc, pix_data} !== expw) begin
          n_fail++;
          $display("[TB] FAIL word[%0d]: got dc=%b data=%h required dc=%b data=%h",
                   hs, pix_dc, pix_data, expw[16], expw[15:0]);
        end
        hs++;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
      prev_dc    = pix_dc;
    end
    diff = 1'b0;
    pix_ready = 1'b1;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("[TB] FAIL tile_timeout: busy=%b still high, required 0 within 5000 cycles", busy);
    end
    n_checks++;
    if (hs != 411) begin
      n_fail++;
      $display("[TB] FAIL handshakes: got %0d required 411", hs);
    end
    n_checks++;
    if (pix_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL valid_after_tile: got %b required 0", pix_valid);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; run = 1'b1; diff = 1'b0; x = '0; y = '0; obj_code = '0; pix_ready = 1'b1;
    #12;
    n_checks++;
    if ({pix_valid, busy, sweep_done, scan_en, pix_dc, pix_data} !== {5'b00010, 16'h0000}) begin
      n_fail++;
      $display("[TB] FAIL reset_run1: got valid=%b busy=%b sweep=%b scan_en=%b dc=%b data=%h required 0,0,0,1,0,0000",
               pix_valid, busy, sweep_done, scan_en, pix_dc, pix_data);
    end
    run = 1'b0;
    #1;
    n_checks++;
    if (scan_en !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_run0: scan_en=%b required 0", scan_en);
    end
    @(negedge clk);
    nrst = 1'b1;
    run = 1'b1;
  endtask

  task automatic test_basic_tile();
    int hs, low, sw;
    run_tile(4'd3, 4'd2, 3'd1, 0, 0, 0, hs, low, sw);
    n_checks++;
    if (low != 411) begin
      n_fail++;
      $display("[TB] FAIL scan_en_low: got %0d cycles required 411", low);
    end
    n_checks++;
    if (scan_en !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL scan_en_reassert: got %b required 1", scan_en);
    end
  endtask

  task automatic test_backpressure();
    int hs, low, sw;
    run_tile(4'd3, 4'd2, 3'd1, 1, 0, 0, hs, low, sw);
  endtask

  task automatic test_corner();
    int hs, low, sw;
    run_tile(4'd15, 4'd11, 3'd4, 0, 0, 0, hs, low, sw);
    n_checks++;
    if (sw != 1) begin
      n_fail++;
      $display("[TB] FAIL corner_sweep: got %0d pulses required 1", sw);
    end
  endtask

  task automatic test_bad_code();
    int hs, low, sw;
    run_tile(4'd7, 4'd4, 3'd6, 0, 0, 0, hs, low, sw);
  endtask

  task automatic test_diff_while_busy();
    int hs, low, sw;
    int extra;
    run_tile(4'd1, 4'd9, 3'd2, 0, 1, 0, hs, low, sw);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || pix_valid) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("[TB] FAIL second_tile: got %0d busy cycles required 0", extra);
    end
  endtask

  task automatic test_sweep();
    int sweeps, valids;
    sweeps = 0; valids = 0;
    diff = 1'b0; run = 1'b1;
    for (int i = 0; i < 385; i++) begin
      @(negedge clk);
      if (sweep_done) sweeps++;
      if (pix_valid) valids++;
      x = 4'((i % 192) % 16);
      y = 4'((i % 192) / 16);
    end
    x = 4'd0; y = 4'd0;
    n_checks++;
    if (sweeps != 2) begin
      n_fail++;
      $display("[TB] FAIL sweep_count: got %0d required 2", sweeps);
    end
    n_checks++;
    if (valids != 0) begin
      n_fail++;
      $display("[TB] FAIL sweep_valid: got %0d valid cycles required 0", valids);
    end
  endtask

  task automatic test_run_pause();
    int hs, low, sw;
    int caps;
    run_tile(4'd8, 4'd6, 3'd3, 0, 0, 1, hs, low, sw);
    caps = 0;
    diff = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (scan_en || busy) caps++;
    end
    diff = 1'b0;
    run = 1'b1;
    n_checks++;
    if (caps != 0) begin
      n_fail++;
      $display("[TB] FAIL run_pause: got %0d active cycles required 0", caps);
    end
  endtask

  task automatic test_reset_mid_tile();
    int hs, low, sw;
    @(negedge clk);
    run = 1'b1; x = 4'd2; y = 4'd3; obj_code = 3'd2; diff = 1'b1; pix_ready = 1'b1;
    @(posedge clk);
    #1 diff = 1'b0; x = 4'd0; y = 4'd0;
    repeat (111) @(negedge clk);
    n_checks++;
    if ({busy, pix_valid, pix_dc, pix_data} !== {3'b111, 16'h07E0}) begin
      n_fail++;
      $display("[TB] FAIL pre_abort: got busy=%b valid=%b dc=%b data=%h required 1,1,1,07e0",
               busy, pix_valid, pix_dc, pix_data);
    end
    #2 nrst = 1'b0;
    #1;
    n_checks++;
    if ({pix_valid, busy, sweep_done, scan_en, pix_dc, pix_data} !== {5'b00010, 16'h0000}) begin
      n_fail++;
      $display("[TB] FAIL abort: got valid=%b busy=%b sweep=%b scan_en=%b dc=%b data=%h required 0,0,0,1,0,0000",
               pix_valid, busy, sweep_done, scan_en, pix_dc, pix_data);
    end
    @(negedge clk);
    nrst = 1'b1;
    run_tile(4'd10, 4'd0, 3'd0, 0, 0, 0, hs, low, sw);
  endtask

  initial begin
    test_reset();
    test_basic_tile();
    test_backpressure();
    test_corner();
    test_bad_code();
    test_diff_while_busy();
    test_sweep();
    test_run_pause();
    test_reset_mid_tile();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
